// File: rtl/axi_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_arbiter_if
// Brief    : AW/W bundle between NB_SLAVE requesters and one master write path.
// Revision : 1.0
// ============================================================================
interface axi_write_arbiter_if #(
    parameter int NB_SLAVE = 4,
    parameter int AW_WIDTH = 64,
    parameter int W_WIDTH  = 40
);
    localparam int SRC_W = $clog2(NB_SLAVE);

    logic [NB_SLAVE-1:0]          slave_aw_valid_i;
    logic [NB_SLAVE*AW_WIDTH-1:0] slave_aw_data_i;
    logic [NB_SLAVE-1:0]          slave_aw_ready_o;
    logic                         master_aw_valid_o;
    logic [AW_WIDTH-1:0]          master_aw_data_o;
    logic [SRC_W-1:0]             master_aw_src_o;
    logic                         master_aw_ready_i;

    logic [NB_SLAVE-1:0]          slave_w_valid_i;
    logic [NB_SLAVE*W_WIDTH-1:0]  slave_w_data_i;
    logic [NB_SLAVE-1:0]          slave_w_last_i;
    logic [NB_SLAVE-1:0]          slave_w_ready_o;
    logic                         master_w_valid_o;
    logic [W_WIDTH-1:0]           master_w_data_o;
    logic                         master_w_last_o;
    logic                         master_w_ready_i;

    // master: the arbiter, which drives the shared downstream write path
    modport master (
        input  slave_aw_valid_i, slave_aw_data_i, master_aw_ready_i,
        input  slave_w_valid_i, slave_w_data_i, slave_w_last_i, master_w_ready_i,
        output slave_aw_ready_o, master_aw_valid_o, master_aw_data_o, master_aw_src_o,
        output slave_w_ready_o, master_w_valid_o, master_w_data_o, master_w_last_o
    );

    modport slave (
        output slave_aw_valid_i, slave_aw_data_i, master_aw_ready_i,
        output slave_w_valid_i, slave_w_data_i, slave_w_last_i, master_w_ready_i,
        input  slave_aw_ready_o, master_aw_valid_o, master_aw_data_o, master_aw_src_o,
        input  slave_w_ready_o, master_w_valid_o, master_w_data_o, master_w_last_o
    );
endinterface
`default_nettype wire

// File: rtl/axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_arbiter
// Brief    : Round-robin AW arbiter with in-order W routing via a grant FIFO.
// Revision : 1.0
// ============================================================================
module axi_write_arbiter #(
    parameter int NB_SLAVE   = 4,
    parameter int AW_WIDTH   = 64,
    parameter int W_WIDTH    = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi_write_arbiter_if.master           bus,
    output logic [$clog2(FIFO_DEPTH):0]   outstanding_o
);
    localparam int IDX_W = $clog2(NB_SLAVE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t      r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, r_lock_idx, w_grant_idx, w_head;
    logic             w_grant_valid, w_aw_hs, w_pop, w_full, w_empty, w_head_valid;
    logic [IDX_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr, r_rd_ptr, r_outstanding;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    // Reverse scan so the requester closest to r_rr_ptr is assigned last and wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = r_rr_ptr;
        if (rst_n && !w_full) begin
            if (r_state == ST_LOCKED) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = r_lock_idx;
            end else begin
                for (int i = NB_SLAVE - 1; i >= 0; i--) begin
                    if (bus.slave_aw_valid_i[IDX_W'((int'(r_rr_ptr) + i) % NB_SLAVE)]) begin
                        w_grant_valid = 1'b1;
                        w_grant_idx   = IDX_W'((int'(r_rr_ptr) + i) % NB_SLAVE);
                    end
                end
            end
        end
    end

    assign w_aw_hs               = w_grant_valid && bus.master_aw_ready_i;
    assign bus.master_aw_valid_o = w_grant_valid;
    assign bus.master_aw_src_o   = w_grant_valid ? w_grant_idx : '0;
    assign bus.master_aw_data_o  = w_grant_valid ?
                                   bus.slave_aw_data_i[w_grant_idx*AW_WIDTH +: AW_WIDTH] : '0;

    always_comb begin
        bus.slave_aw_ready_o = '0;
        if (w_grant_valid) begin
            bus.slave_aw_ready_o[w_grant_idx] = bus.master_aw_ready_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OPEN:   if (w_grant_valid && !bus.master_aw_ready_i) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_aw_hs) w_state_nxt = ST_OPEN;
            default:   w_state_nxt = ST_OPEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OPEN;
            r_lock_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_OPEN && w_state_nxt == ST_LOCKED) begin
                r_lock_idx <= w_grant_idx;
            end
        end
    end

    // W channel follows the oldest granted burst only
    assign w_head                = r_fifo[r_rd_ptr[PTR_W-1:0]];
    assign w_head_valid          = !w_empty && bus.slave_w_valid_i[w_head];
    assign bus.master_w_valid_o  = w_head_valid;
    assign bus.master_w_data_o   = w_empty ? '0 : bus.slave_w_data_i[w_head*W_WIDTH +: W_WIDTH];
    assign bus.master_w_last_o   = !w_empty && bus.slave_w_last_i[w_head];
    assign w_pop                 = w_head_valid && bus.master_w_ready_i && bus.slave_w_last_i[w_head];

    always_comb begin
        bus.slave_w_ready_o = '0;
        if (!w_empty) begin
            bus.slave_w_ready_o[w_head] = bus.master_w_ready_i;
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_aw_hs) begin
                r_rr_ptr <= (w_grant_idx == IDX_W'(NB_SLAVE - 1)) ? '0 : w_grant_idx + 1'b1;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_aw_hs, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign outstanding_o = r_outstanding;

    a_aw_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.master_aw_valid_o && !bus.master_aw_ready_i) |=>
        (bus.master_aw_valid_o && $stable(bus.master_aw_data_o) && $stable(bus.master_aw_src_o)));
    a_w_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.master_w_valid_o && !bus.master_w_ready_i) |=>
        ($stable(bus.master_w_data_o) && $stable(bus.master_w_last_o)));
    a_aw_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.slave_aw_ready_o));
    a_w_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.slave_w_ready_o));
endmodule
`default_nettype wire

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
- Shares one AXI master-side write path (AW + W channels) among NB_SLAVE slave-side requesters.
- Round-robin arbitration on AW; grant stays locked until the AW handshake completes.
- Granted requester indices are queued in order, and the W channel is routed to the head requester until its WLAST beat is accepted.
- Placed in front of each master port of the AXI node, between the node's write routing and any multicut slices.

Parameters:
NB_SLAVE, 4, number of requesting slave ports (>=2)
AW_WIDTH, 64, packed AW payload bits per requester (addr/len/size/burst/id/user)
W_WIDTH, 40, packed W payload bits per requester (data/strb/user, excluding last)
FIFO_DEPTH, 4, max write bursts granted on AW whose W data is not yet complete (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset
slave_aw_valid_i  in  NB_SLAVE  AW valid per requester
slave_aw_data_i  in  NB_SLAVE*AW_WIDTH  AW payload, requester i at bits [i*AW_WIDTH +: AW_WIDTH]
slave_aw_ready_o  out  NB_SLAVE  AW ready per requester
master_aw_valid_o  out  1  arbitrated AW valid
master_aw_data_o  out  AW_WIDTH  arbitrated AW payload
master_aw_src_o  out  $clog2(NB_SLAVE)  index of granted requester (prepended to ID by node)
master_aw_ready_i  in  1  downstream AW ready
slave_w_valid_i  in  NB_SLAVE  W valid per requester
slave_w_data_i  in  NB_SLAVE*W_WIDTH  W payload, same packing as AW
slave_w_last_i  in  NB_SLAVE  W last per requester
slave_w_ready_o  out  NB_SLAVE  W ready per requester
master_w_valid_o  out  1  routed W valid
master_w_data_o  out  W_WIDTH  routed W payload
master_w_last_o  out  1  routed W last
master_w_ready_i  in  1  downstream W ready
outstanding_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Interface (already decided): single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - All ready/valid outputs 0; data outputs are don't-care and are driven with 0.
  - RR pointer = 0 (requester 0 has highest priority); FIFO empty; outstanding_o = 0; lock cleared.
- Reset mid-burst: all state is dropped immediately; no partial bursts are remembered.
- AW arbitration (combinational, zero latency):
  - When unlocked and FIFO not full, grant goes to the first requester with aw_valid, scanning from ptr, ptr+1, ... modulo NB_SLAVE.
  - master_aw_valid_o = grant exists; data and src are muxed from the granted requester.
  - slave_aw_ready_o[g] = master_aw_ready_i for the granted requester g; 0 for all others.
- Lock:
  - If master_aw_valid_o=1 and master_aw_ready_i=0, the granted index g is registered as locked.
  - While locked, the grant stays on g regardless of other requesters, so valid and payload remain stable.
  - Lock clears on the handshake.
- On an AW handshake:
  - ptr <= g+1 (wraps at NB_SLAVE).
  - g is pushed into the FIFO.
- FIFO full (occupancy == FIFO_DEPTH):
  - master_aw_valid_o = 0 and all slave_aw_ready_o = 0.
  - A pop in the same cycle does not enable a push; AW resumes the next cycle.
  - A lock taken before the FIFO filled cannot occur, because valid drops only when no grant is pending; the FIFO can only become full on a handshake, which clears the lock.
- W routing:
  - h = FIFO head.
  - master_w_valid_o = !empty & slave_w_valid_i[h]; payload and last come from h.
  - slave_w_ready_o[h] = !empty & master_w_ready_i; all other requesters get 0.
  - W beats from non-head requesters stall (AXI permits W before AW; they wait).
- Ordering and latency:
  - The FIFO pops on a W handshake with last=1.
  - The FIFO push is registered, so the first W beat can transfer no earlier than the cycle after its AW handshake.
- Simultaneous push and pop (FIFO not full): occupancy is unchanged, and the head advances correctly even at occupancy 1.
- Pointer wrap-around: read and write pointers are $clog2(FIFO_DEPTH) bits with an extra wrap bit for full/empty detection.
- outstanding_o = occupancy, registered.
- Assertions:
  - Payload stability while valid & !ready on both master channels.
  - At most one bit set in slave_aw_ready_o and in slave_w_ready_o.

Test Plan:
1. All 4 requesters assert aw_valid at once with ready=1 and single-beat W → grants in order 0,1,2,3; src sequence 0,1,2,3; W last beats forwarded in the same order; outstanding_o returns to 0.
2. Requester 2 AW with master_aw_ready_i=0 for 5 cycles, then requester 0 asserts valid → grant stays on 2 with stable data until ready; requester 0 is granted on the next arbitration.
3. Four AW handshakes (FIFO_DEPTH=4) with W withheld → outstanding_o=4; a fifth aw_valid sees ready=0; after one WLAST completes, the fifth is accepted in the following cycle.
4. Requester 1 sends W beats (len=3) before its AW → slave_w_ready_o[1]=0 until the cycle after the AW handshake; then 4 beats pass and the pop occurs on the last.
5. Two bursts queued (src 3 then 0); requester 0 presents W first → requester 0 stalls until requester 3's WLAST, then proceeds.
6. Assert rst_n low mid-burst with outstanding_o=2 → all ready/valid outputs are 0 immediately; after release, requester 0 has top priority and FIFO is empty.
